// File: rtl/if_id_buffer_pkg.sv
// Constants shared by the fetch/decode boundary: NOP filler word, HALT opcode and
// the opcode field position, also used by decode's hazard/NOP-insertion logic.
package if_id_buffer_pkg;

    localparam logic [15:0] DEF_NOP_INST = 16'h0800;
    localparam logic [4:0]  DEF_HALT_OPC = 5'b00000;
    localparam int          OPC_MSB      = 15;
    localparam int          OPC_LSB      = 11;

    function automatic logic [4:0] opcode_of(input logic [15:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy control for a small circular buffer.
// Flush has priority over push/pop and returns everything to slot 0.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count
);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID boundary FIFO: buffers instruction/PC_inc pairs from fetch, squashes on flush,
// and stops accepting fetch words once a HALT has been captured.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// in_ready depends only on registered state, and flush suppresses both transfers.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_INST = DEF_NOP_INST,
    parameter logic [4:0]  HALT_OPC = DEF_HALT_OPC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                in_inst,
    input  logic [15:0]                in_pc_inc,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [15:0]                out_inst,
    output logic [15:0]                out_pc_inc,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic                       halt_seen,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic [31:0]      mem [DEPTH];

    assign in_ready  = (count < CNT_W'(DEPTH)) & ~halt_seen;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count)
    );

    // Storage is never reset; the output mux hides stale contents when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_inst, in_pc_inc};
    end

    assign out_inst   = out_valid ? mem[rd_ptr][31:16] : NOP_INST;
    assign out_pc_inc = out_valid ? mem[rd_ptr][15:0]  : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_seen <= 1'b0;
        end else if (flush) begin
            halt_seen <= 1'b0;
        end else if (push && opcode_of(in_inst) == HALT_OPC) begin
            halt_seen <= 1'b1;
        end
    end

endmodule
